// File: rtl/vc_fifo_onehot_if.sv
// rtl/vc_fifo_onehot_if.sv - write/read handshake and status bundle for the VC input buffer
interface vc_fifo_onehot_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4
) ();
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    wr_en;
    logic [VC_W-1:0]         wr_vc;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    rd_en;
    logic [VC_W-1:0]         rd_vc;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC-1:0]       ready_out;
    logic [NUM_VC-1:0]       almost_full;
    logic [NUM_VC-1:0]       pkt_avail;
    logic [NUM_VC*CNT_W-1:0] occupancy;
    logic                    err_ovf;
    logic                    err_udf;
    logic                    err_vc;

    // Link receiver / allocator side
    modport master (
        output wr_en, wr_vc, data_in, rd_en, rd_vc,
        input  data_out, empty, ready_out, almost_full, pkt_avail, occupancy,
        input  err_ovf, err_udf, err_vc
    );

    // Buffer side
    modport slave (
        input  wr_en, wr_vc, data_in, rd_en, rd_vc,
        output data_out, empty, ready_out, almost_full, pkt_avail, occupancy,
        output err_ovf, err_udf, err_vc
    );
endinterface

// File: rtl/vc_fifo_onehot.sv
// rtl/vc_fifo_onehot.sv - multi-VC router input buffer with one-hot rotating pointers
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

module vc_fifo_onehot #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int DEPTH       = 4,
    parameter int NUM_VC      = 2,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vc_fifo_onehot_if.slave   bus
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] PTR_RST = DEPTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [NUM_VC][DEPTH];
    logic [DEPTH-1:0]      wr_ptr_q [NUM_VC];
    logic [DEPTH-1:0]      wr_ptr_d [NUM_VC];
    logic [DEPTH-1:0]      rd_ptr_q [NUM_VC];
    logic [DEPTH-1:0]      rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0]      occ_q    [NUM_VC];
    logic [CNT_W-1:0]      occ_d    [NUM_VC];
    logic [CNT_W-1:0]      tail_q   [NUM_VC];
    logic [CNT_W-1:0]      tail_d   [NUM_VC];
    logic [DATA_WIDTH-1:0] head     [NUM_VC];
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_udf_q, err_udf_d;
    logic                  err_vc_q,  err_vc_d;

    logic [NUM_VC-1:0] wr_sel, rd_sel, wr_hit, rd_hit, wr_acc, rd_acc;
    logic [NUM_VC-1:0] full_v, empty_v;
    logic              wr_is_tail;

    // Per-VC decode, head mux, accept logic and next-state counters/pointers
    always_comb begin
        wr_sel     = '0;
        rd_sel     = '0;
        full_v     = '0;
        empty_v    = '0;
        head       = '{default: '0};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        tail_d     = tail_q;
        wr_is_tail = (bus.data_in[DATA_WIDTH-1 -: 3] == `TAIL);
        for (int v = 0; v < NUM_VC; v++) begin
            // An out-of-range VC index matches no channel, so it is never accepted
            wr_sel[v]  = (bus.wr_vc == VC_W'(v));
            rd_sel[v]  = (bus.rd_vc == VC_W'(v));
            full_v[v]  = (occ_q[v] == CNT_W'(DEPTH));
            empty_v[v] = (occ_q[v] == '0);
            for (int e = 0; e < DEPTH; e++) begin
                head[v] = head[v] | (mem_q[v][e] & {DATA_WIDTH{rd_ptr_q[v][e]}});
            end
        end
        wr_hit = wr_sel & {NUM_VC{bus.wr_en}};
        rd_hit = rd_sel & {NUM_VC{bus.rd_en}};
        // Status is taken from registered counts only: no bypass, no fall-through
        wr_acc = wr_hit & ~full_v;
        rd_acc = rd_hit & ~empty_v;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_acc[v]) wr_ptr_d[v] = {wr_ptr_q[v][DEPTH-2:0], wr_ptr_q[v][DEPTH-1]};
            if (rd_acc[v]) rd_ptr_d[v] = {rd_ptr_q[v][DEPTH-2:0], rd_ptr_q[v][DEPTH-1]};
            occ_d[v]  = occ_q[v] + CNT_W'(wr_acc[v]) - CNT_W'(rd_acc[v]);
            tail_d[v] = tail_q[v] + CNT_W'(wr_acc[v] & wr_is_tail)
                                  - CNT_W'(rd_acc[v] & (head[v][DATA_WIDTH-1 -: 3] == `TAIL));
        end
        err_ovf_d = err_ovf_q | (|(wr_hit & full_v));
        err_udf_d = err_udf_q | (|(rd_hit & empty_v));
        err_vc_d  = err_vc_q | (bus.wr_en & ~(|wr_sel)) | (bus.rd_en & ~(|rd_sel));
    end

    // Control state: pointers, counters and sticky errors, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= PTR_RST;
                rd_ptr_q[v] <= PTR_RST;
                occ_q[v]    <= '0;
                tail_q[v]   <= '0;
            end
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
            err_vc_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            tail_q    <= tail_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
            err_vc_q  <= err_vc_d;
        end
    end

    // Flit storage is not reset; the one-hot write pointer selects the entry
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_acc[v] && wr_ptr_q[v][e]) mem_q[v][e] <= bus.data_in;
            end
        end
    end

    // Status outputs and show-ahead data, gated to zero for an empty or invalid rd_vc
    always_comb begin
        bus.data_out    = '0;
        bus.occupancy   = '0;
        bus.almost_full = '0;
        bus.pkt_avail   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_sel[v] && !empty_v[v]) bus.data_out = bus.data_out | head[v];
            bus.occupancy[v*CNT_W +: CNT_W] = occ_q[v];
            bus.almost_full[v] = (occ_q[v] >= CNT_W'(AFULL_LEVEL));
            bus.pkt_avail[v]   = (tail_q[v] != '0);
        end
        bus.empty     = empty_v;
        bus.ready_out = ~full_v;
        bus.err_ovf   = err_ovf_q;
        bus.err_udf   = err_udf_q;
        bus.err_vc    = err_vc_q;
    end
endmodule

// File: tb/tb_vc_fifo_onehot.sv
// tb/tb_vc_fifo_onehot.sv - randomized and directed checks of vc_fifo_onehot against a queue model
module tb_vc_fifo_onehot;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NV    = 3;
    localparam int VW    = 2;
    localparam int CW    = 3;
    localparam logic [2:0] T_HDR = 3'b001;
    localparam logic [2:0] T_PAY = 3'b010;
    localparam logic [2:0] T_TAIL = 3'b011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_fifo_onehot_if #(.DATA_WIDTH(DW), .NUM_VC(NV), .DEPTH(DEPTH)) bus ();

    vc_fifo_onehot #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NV), .AFULL_LEVEL(DEPTH-1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mq [NV][$];
    logic m_ovf, m_udf, m_vc;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] flit(input logic [2:0] t, input logic [27:0] body);
        logic [DW-1:0] f;
        f = {t, body, 1'b0};
        f[0] = ^f[DW-1:1];
        return f;
    endfunction

    function automatic int tails_in(input int v);
        int n = 0;
        foreach (mq[v][i]) if (mq[v][i][DW-1 -: 3] == T_TAIL) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_vc  = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        logic [NV-1:0] e_empty, e_ready, e_af, e_pkt;
        logic [DW-1:0] e_data;
        int rv;
        e_data = '0;
        for (int v = 0; v < NV; v++) begin
            e_empty[v] = (mq[v].size() == 0);
            e_ready[v] = (mq[v].size() < DEPTH);
            e_af[v]    = (mq[v].size() >= DEPTH - 1);
            e_pkt[v]   = (tails_in(v) > 0);
            check_eq($sformatf("%s occ%0d", ph, v), 64'(bus.occupancy[v*CW +: CW]), 64'(mq[v].size()));
        end
        rv = int'(bus.rd_vc);
        if (rv < NV) begin
            if (mq[rv].size() > 0) e_data = mq[rv][0];
        end
        check_eq({ph, " empty"}, 64'(bus.empty), 64'(e_empty));
        check_eq({ph, " ready"}, 64'(bus.ready_out), 64'(e_ready));
        check_eq({ph, " afull"}, 64'(bus.almost_full), 64'(e_af));
        check_eq({ph, " pkt"}, 64'(bus.pkt_avail), 64'(e_pkt));
        check_eq({ph, " data"}, 64'(bus.data_out), 64'(e_data));
        check_eq({ph, " ovf"}, 64'(bus.err_ovf), 64'(m_ovf));
        check_eq({ph, " udf"}, 64'(bus.err_udf), 64'(m_udf));
        check_eq({ph, " vcerr"}, 64'(bus.err_vc), 64'(m_vc));
    endtask

    task automatic cyc(input logic we, input int wv, input logic [DW-1:0] d,
                       input logic re, input int rv, input string ph);
        logic wacc, racc;
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_vc   = VW'(wv);
        bus.data_in = d;
        bus.rd_en   = re;
        bus.rd_vc   = VW'(rv);
        wacc = 1'b0;
        racc = 1'b0;
        if (we) begin
            if (wv >= NV) m_vc = 1'b1;
            else if (mq[wv].size() == DEPTH) m_ovf = 1'b1;
            else wacc = 1'b1;
        end
        if (re) begin
            if (rv >= NV) m_vc = 1'b1;
            else if (mq[rv].size() == 0) m_udf = 1'b1;
            else racc = 1'b1;
        end
        @(posedge clk);
        if (racc) void'(mq[rv].pop_front());
        if (wacc) mq[wv].push_back(d);
        #1;
        check_outputs(ph);
    endtask

    function automatic logic [DW-1:0] rnd_flit();
        logic [2:0] t;
        t = 3'($urandom_range(1, 3));
        return flit(t, 28'($urandom));
    endfunction

    initial begin
        bus.wr_en = 1'b0; bus.wr_vc = '0; bus.data_in = '0;
        bus.rd_en = 1'b0; bus.rd_vc = '0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill VC0 with one complete packet
        cyc(1, 0, flit(T_HDR, 28'h0000001), 0, 0, "t1");
        cyc(1, 0, flit(T_PAY, 28'h0000002), 0, 0, "t1");
        cyc(1, 0, flit(T_PAY, 28'h0000003), 0, 0, "t1");
        cyc(1, 0, flit(T_TAIL, 28'h0000004), 0, 0, "t1");

        // Overflow then drain in order
        cyc(1, 0, flit(T_PAY, 28'hBAD0000), 0, 0, "t2ovf");
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0, "t2pop");

        // Interleave across VCs with pointer wrap
        cyc(1, 0, flit(T_HDR, 28'h0000010), 0, 0, "t3pre");
        cyc(1, 0, flit(T_PAY, 28'h0000011), 0, 0, "t3pre");
        cyc(1, 1, flit(T_HDR, 28'h0000020), 0, 1, "t3pre");
        cyc(1, 1, flit(T_PAY, 28'h0000021), 0, 1, "t3pre");
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) cyc(1, 0, flit(T_PAY, 28'(32'h100 + i)), 1, 1, "t3");
            else            cyc(1, 1, flit(T_TAIL, 28'(32'h200 + i)), 1, 0, "t3");
        end

        // Concurrent write+read on one VC holds occupancy
        for (int i = 0; i < 6; i++) cyc(1, 1, flit((i == 5) ? T_TAIL : T_PAY, 28'(32'h300 + i)), 1, 1, "t4");

        // Underflow and out-of-range VC
        cyc(0, 0, '0, 1, 1, "t5drain");
        cyc(0, 0, '0, 1, 1, "t5drain");
        cyc(0, 0, '0, 1, 1, "t5udf");
        cyc(0, 0, '0, 1, 3, "t5vc");
        cyc(1, 3, flit(T_HDR, 28'h0000555), 0, 0, "t5vcw");

        // Asynchronous reset mid-packet
        while (mq[0].size() > 0) cyc(0, 0, '0, 1, 0, "t6drain");
        cyc(1, 0, flit(T_HDR, 28'h0000601), 0, 0, "t6fill");
        cyc(1, 0, flit(T_PAY, 28'h0000602), 0, 0, "t6fill");
        cyc(1, 0, flit(T_PAY, 28'h0000603), 0, 0, "t6fill");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("t6rst");
        @(posedge clk);
        #1;
        check_outputs("t6rsthold");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, flit(T_HDR, 28'h0000777), 0, 0, "t6hdr");

        // Randomized traffic, including out-of-range VCs
        for (int i = 0; i < 400; i++) begin
            int wv, rv;
            wv = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, NV - 1));
            rv = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, NV - 1));
            cyc(logic'($urandom_range(0, 9) < 6), wv, rnd_flit(),
                logic'($urandom_range(0, 9) < 5), rv, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
